// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S transmit serializer with one-entry sample holding register and underrun counting
module audio_i2s_tx #(
    parameter int SAMPLE_W       = 16,
    parameter int UNDERRUN_CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pll_locked,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic [SAMPLE_W-1:0]       sample_left,
    input  logic [SAMPLE_W-1:0]       sample_right,
    output logic                      i2s_bclk,
    output logic                      i2s_lrck,
    output logic                      i2s_dacdat,
    output logic                      underrun,
    output logic [UNDERRUN_CNT_W-1:0] underrun_count
);
    localparam int CW = $clog2(4*SAMPLE_W);
    localparam logic [CW-1:0] LAST = CW'(4*SAMPLE_W-1);
    localparam logic [CW-2:0] LR_LO = (CW-1)'(SAMPLE_W-1);
    localparam logic [CW-2:0] LR_HI = (CW-1)'(2*SAMPLE_W-2);
    logic [CW-1:0]           r_c;
    logic [2*SAMPLE_W-1:0]   r_sh;
    logic [2*SAMPLE_W-1:0]   r_hold;
    logic                    r_full;
    logic                    r_ready;
    logic                    r_lrck;
    logic                    r_underrun;
    logic [UNDERRUN_CNT_W-1:0] r_cnt;
    logic                    w_last;
    logic                    w_xfer;
    logic                    w_full_n;
    logic [CW-1:0]           w_c_n;
    logic [CW-2:0]           w_slot_n;
    assign w_last   = r_c == LAST;
    assign w_xfer   = sample_valid & r_ready;
    assign w_full_n = w_xfer | (r_full & ~w_last);
    assign w_c_n    = w_last ? '0 : r_c + CW'(1);
    assign w_slot_n = w_c_n[CW-1:1];
    always_ff @(posedge clk) begin
        if (rst || !pll_locked) begin
            r_c        <= '0;
            r_sh       <= '0;
            r_full     <= 1'b0;
            r_ready    <= 1'b0;
            r_lrck     <= 1'b0;
            r_underrun <= 1'b0;
            if (rst) r_cnt <= '0;
        end else begin
            r_c        <= w_c_n;
            r_full     <= w_full_n;
            r_ready    <= ~w_full_n;
            r_lrck     <= (w_slot_n >= LR_LO) && (w_slot_n <= LR_HI);
            // Pulse is asserted for the cycle the counter sits at LAST with nothing to load.
            r_underrun <= (w_c_n == LAST) & ~w_full_n;
            if (w_last) begin
                r_sh <= r_full ? r_hold : '0;
                if (!r_full && r_cnt != '1) r_cnt <= r_cnt + UNDERRUN_CNT_W'(1);
            end else if (r_c[0]) begin
                r_sh <= r_sh << 1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (w_xfer) r_hold <= {sample_left, sample_right};
    end
    assign sample_ready   = r_ready;
    assign i2s_bclk       = r_c[0];
    assign i2s_lrck       = r_lrck;
    assign i2s_dacdat     = r_sh[2*SAMPLE_W-1];
    assign underrun       = r_underrun;
    assign underrun_count = r_cnt;
endmodule
